// File: rtl/hex_key_entry.sv
// Operator hex keypad front end: synchronises and debounces switch/button input,
// assembles 16-bit words and hands them to the CPU over a 4-phase req/valid handshake.
module hex_key_entry #(
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int CNT_W           = 18
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  sw,
  input  logic        btn_push_n,
  input  logic        btn_clear_n,
  input  logic        btn_commit_n,
  input  logic        in_req,
  output logic        in_valid,
  output logic [15:0] in_data,
  output logic [15:0] entry,
  output logic [2:0]  digit_cnt,
  output logic        waiting
);

  typedef enum logic [1:0] {IDLE, WAIT_USER, HOLD} state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state, state_nxt;
  logic [3:0]       sw_p0, sw_p1;
  logic [2:0]       btn_p0, btn_p1;       // bit 0 push, bit 1 clear, bit 2 commit
  logic [2:0]       btn_deb, btn_deb_d;
  logic [CNT_W-1:0] db_cnt [3];
  logic [2:0]       press_evt;
  logic             push_evt, clear_evt, commit_evt, commit_acc;

  // Stage p0/p1: two-flop synchronisers; buttons idle released (high)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_p0  <= '0;
      sw_p1  <= '0;
      btn_p0 <= '1;
      btn_p1 <= '1;
    end else begin
      sw_p0  <= sw;
      sw_p1  <= sw_p0;
      btn_p0 <= {btn_commit_n, btn_clear_n, btn_push_n};
      btn_p1 <= btn_p0;
    end
  end

  // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_deb   <= '1;
      btn_deb_d <= '1;
      for (int b = 0; b < 3; b++) db_cnt[b] <= '0;
    end else begin
      btn_deb_d <= btn_deb;
      for (int b = 0; b < 3; b++) begin
        if (btn_p1[b] == btn_deb[b]) begin
          db_cnt[b] <= '0;
        end else if (db_cnt[b] == DB_LAST) begin
          btn_deb[b] <= btn_p1[b];
          db_cnt[b]  <= '0;
        end else begin
          db_cnt[b] <= db_cnt[b] + 1'b1;
        end
      end
    end
  end

  assign press_evt  = btn_deb_d & ~btn_deb;
  assign push_evt   = press_evt[0];
  assign clear_evt  = press_evt[1];
  assign commit_evt = press_evt[2];
  assign commit_acc = commit_evt && (state == WAIT_USER);

  // Entry register: an accepted commit outranks clear, which outranks push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry     <= '0;
      digit_cnt <= '0;
      in_data   <= '0;
    end else if (commit_acc) begin
      in_data   <= entry;
      entry     <= '0;
      digit_cnt <= '0;
    end else if (clear_evt) begin
      entry     <= '0;
      digit_cnt <= '0;
    end else if (push_evt) begin
      entry <= {entry[11:0], sw_p1};
      if (digit_cnt != 3'd4) digit_cnt <= digit_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (in_req) state_nxt = WAIT_USER;
      WAIT_USER: begin
        if (commit_acc)   state_nxt = HOLD;
        else if (!in_req) state_nxt = IDLE;
      end
      HOLD:      if (!in_req) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  assign in_valid = (state == HOLD);
  assign waiting  = (state == WAIT_USER);

endmodule

// File: tb/tb_hex_key_entry.sv
// Bench for hex_key_entry: directed test-plan scenarios plus randomized button/request
// activity, all checked every cycle against a window-based behavioural model.
module tb_hex_key_entry;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  sw = 4'h0;
  logic        btn_push_n = 1'b1, btn_clear_n = 1'b1, btn_commit_n = 1'b1;
  logic        in_req = 1'b0;
  logic        in_valid, waiting;
  logic [15:0] in_data, entry;
  logic [2:0]  digit_cnt;

  int checks = 0;
  int errors = 0;

  hex_key_entry #(.DEBOUNCE_CYCLES(DB), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw),
    .btn_push_n(btn_push_n), .btn_clear_n(btn_clear_n), .btn_commit_n(btn_commit_n),
    .in_req(in_req), .in_valid(in_valid), .in_data(in_data),
    .entry(entry), .digit_cnt(digit_cnt), .waiting(waiting)
  );

  always #5 clk = ~clk;

  // Behavioural model: a level is accepted once the last DB synced samples all disagree with it
  int          m_state;   // 0 idle, 1 waiting for user, 2 holding data
  logic [15:0] m_entry, m_data;
  int          m_cnt;
  logic [3:0]  m_sw0, m_sw1;
  logic [2:0]  m_b0, m_b1, m_deb, m_pend;
  logic [2:0]  m_win [DB];

  task automatic model_reset();
    m_state = 0; m_entry = '0; m_data = '0; m_cnt = 0;
    m_sw0 = '0; m_sw1 = '0; m_b0 = '1; m_b1 = '1; m_deb = '1; m_pend = '0;
    for (int i = 0; i < DB; i++) m_win[i] = '1;
  endtask

  task automatic model_step();
    logic [2:0] ev;
    bit acc, all_diff;
    ev  = m_pend;
    acc = ev[2] && (m_state == 1);
    if (acc) begin
      m_data = m_entry; m_entry = '0; m_cnt = 0;
    end else if (ev[1]) begin
      m_entry = '0; m_cnt = 0;
    end else if (ev[0]) begin
      m_entry = (m_entry << 4) | {12'h000, m_sw1};
      m_cnt   = (m_cnt >= 4) ? 4 : m_cnt + 1;
    end
    case (m_state)
      0: if (in_req) m_state = 1;
      1: if (acc) m_state = 2; else if (!in_req) m_state = 0;
      default: if (!in_req) m_state = 0;
    endcase
    for (int i = DB - 1; i > 0; i--) m_win[i] = m_win[i-1];
    m_win[0] = m_b1;
    m_pend = '0;
    for (int b = 0; b < 3; b++) begin
      all_diff = 1'b1;
      for (int i = 0; i < DB; i++) if (m_win[i][b] == m_deb[b]) all_diff = 1'b0;
      if (all_diff) begin
        m_pend[b] = m_deb[b];
        m_deb[b]  = ~m_deb[b];
      end
    end
    m_sw1 = m_sw0; m_sw0 = sw;
    m_b1  = m_b0;  m_b0  = {btn_commit_n, btn_clear_n, btn_push_n};
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("m_in_valid",  16'(in_valid),  16'(m_state == 2));
      check("m_waiting",   16'(waiting),   16'(m_state == 1));
      check("m_in_data",   in_data,        m_data);
      check("m_entry",     entry,          m_entry);
      check("m_digit_cnt", 16'(digit_cnt), 16'(m_cnt));
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(int b, logic v);
    case (b)
      0: btn_push_n = v;
      1: btn_clear_n = v;
      default: btn_commit_n = v;
    endcase
  endtask

  task automatic press(int b, logic [3:0] d);
    @(negedge clk);
    sw = d;
    set_btn(b, 1'b0);
    tick(8);
    set_btn(b, 1'b1);
    tick(8);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  int dwell [3];
  logic [2:0] lvl;

  initial begin
    tick(3);
    check("rst_in_valid", 16'(in_valid), 16'h0);
    check("rst_entry", entry, 16'h0);
    check("rst_in_data", in_data, 16'h0);
    check("rst_digit_cnt", 16'(digit_cnt), 16'h0);
    check("rst_waiting", 16'(waiting), 16'h0);
    rst_n = 1'b1;
    tick(2);

    // 1: digit entry and fifth-digit overflow
    press(0, 4'h1); press(0, 4'h2); press(0, 4'h3); press(0, 4'h4);
    check("t1_entry", entry, 16'h1234);
    check("t1_cnt", 16'(digit_cnt), 16'd4);
    press(0, 4'hA);
    check("t1_entry5", entry, 16'h234A);
    check("t1_cnt5", 16'(digit_cnt), 16'd4);

    // 2: bouncing press gives one shift; short glitch gives none
    press(1, 4'h0);
    sw = 4'h5;
    for (int i = 0; i < 5; i++) begin
      btn_push_n = 1'b0; tick(2);
      btn_push_n = 1'b1; tick(2);
    end
    btn_push_n = 1'b0; tick(8);
    btn_push_n = 1'b1; tick(8);
    check("t2_entry", entry, 16'h0005);
    check("t2_cnt", 16'(digit_cnt), 16'd1);
    sw = 4'h6;
    btn_push_n = 1'b0; tick(3);
    btn_push_n = 1'b1; tick(10);
    check("t2_glitch", entry, 16'h0005);

    // 3: full handshake
    press(1, 4'h0);
    press(0, 4'hB); press(0, 4'hE); press(0, 4'hE); press(0, 4'hF);
    in_req = 1'b1; tick(2);
    check("t3_waiting", 16'(waiting), 16'h1);
    press(2, 4'h0);
    check("t3_valid", 16'(in_valid), 16'h1);
    check("t3_data", in_data, 16'hBEEF);
    check("t3_entry", entry, 16'h0);
    check("t3_cnt", 16'(digit_cnt), 16'h0);
    in_req = 1'b0; tick(1);
    check("t3_valid_drop", 16'(in_valid), 16'h0);
    check("t3_waiting_drop", 16'(waiting), 16'h0);

    // 4: commit with no request is ignored
    press(0, 4'hC); press(0, 4'h5);
    press(2, 4'h0);
    check("t4_valid", 16'(in_valid), 16'h0);
    check("t4_entry", entry, 16'h00C5);
    check("t4_cnt", 16'(digit_cnt), 16'd2);

    // 5: simultaneous events
    press(0, 4'h1);
    @(negedge clk); sw = 4'h9; btn_push_n = 1'b0; btn_clear_n = 1'b0;
    tick(8); btn_push_n = 1'b1; btn_clear_n = 1'b1; tick(8);
    check("t5_clear_wins", entry, 16'h0);
    press(0, 4'h3); press(0, 4'h7);
    in_req = 1'b1; tick(2);
    @(negedge clk); sw = 4'h8; btn_push_n = 1'b0; btn_commit_n = 1'b0;
    tick(8); btn_push_n = 1'b1; btn_commit_n = 1'b1; tick(8);
    check("t5_data", in_data, 16'h0037);
    check("t5_entry", entry, 16'h0);
    in_req = 1'b0; tick(3);

    // 6: abort keeps entry; reset in HOLD clears immediately
    press(1, 4'h0); press(0, 4'h7);
    in_req = 1'b1; tick(2);
    check("t6_waiting", 16'(waiting), 16'h1);
    in_req = 1'b0; tick(2);
    check("t6_abort_wait", 16'(waiting), 16'h0);
    check("t6_abort_entry", entry, 16'h0007);
    in_req = 1'b1; tick(2);
    press(2, 4'h0);
    for (int i = 0; i < 40 && !in_valid; i++) tick(1);
    check("t6_hold_valid", 16'(in_valid), 16'h1);
    check("t6_hold_data", in_data, 16'h0007);
    press(0, 4'h2);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 16'(in_valid), 16'h0);
    check("t6_rst_data", in_data, 16'h0);
    check("t6_rst_entry", entry, 16'h0);
    check("t6_rst_cnt", 16'(digit_cnt), 16'h0);
    in_req = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
    tick(4);

    // Randomized operator and CPU activity, checked every cycle by the model
    lvl = 3'b111;
    for (int b = 0; b < 3; b++) dwell[b] = $urandom_range(10, 30);
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) sw = 4'($urandom_range(0, 15));
      for (int b = 0; b < 3; b++) begin
        if (dwell[b] == 0) begin
          lvl[b] = ~lvl[b];
          dwell[b] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 30);
        end else begin
          dwell[b]--;
        end
      end
      btn_push_n = lvl[0]; btn_clear_n = lvl[1]; btn_commit_n = lvl[2];
      if (in_req && in_valid && $urandom_range(0, 3) == 0) in_req = 1'b0;
      else if (in_req && !in_valid && $urandom_range(0, 150) == 0) in_req = 1'b0;
      else if (!in_req && $urandom_range(0, 30) == 0) in_req = 1'b1;
    end
    btn_push_n = 1'b1; btn_clear_n = 1'b1; btn_commit_n = 1'b1; in_req = 1'b0;
    tick(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
